fpro_bridge_multi: RTL and testbench

- Parametrised successor to the fixed two-slot MCS-to-FPro bridge.
- Converts MicroBlaze MCS IO-bus transactions into FPro bus cycles across N_REGION chip-select regions.
- Adds per-access byte enables, configurable read latency, slave wait-stretching and unmapped-access termination.
- Sits between the cpu core and the mmio/video subsystems in the MCS top level.

---
 rtl/fpro_brg_pkg.sv | 32 +++
 rtl/fpro_brg_decode.sv | 34 +++
 rtl/fpro_bridge_multi.sv | 172 +++++++++++++++++
 tb/tb_fpro_bridge_multi.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpro_brg_pkg.sv
// ============================================================================
// Module   : fpro_brg_pkg
// Brief    : Shared types, constants and region decode helper for the
//            multi-region MCS-to-FPro bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpro_brg_pkg;

  localparam int          FP_ADDR_W    = 21;
  localparam logic [31:0] BRG_ERR_DATA = 32'hDEAD_BEEF;
  localparam int          REGION_MAX_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } brg_state_t;

  // Region index is the top region_w bits of the 8 MiB bridge window.
  function automatic logic [REGION_MAX_W-1:0] region_of(input logic [31:0] addr,
                                                        input int region_w);
    logic [REGION_MAX_W-1:0] top_bits;
    top_bits = addr[22:20];
    return top_bits >> (REGION_MAX_W - region_w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpro_brg_decode.sv
// ============================================================================
// Module   : fpro_brg_decode
// Brief    : Combinational window match and chip-select region decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpro_brg_decode
  import fpro_brg_pkg::*;
#(
  parameter logic [31:0] BRG_BASE = 32'hc000_0000,
  parameter int          N_REGION = 2
) (
  input  logic [31:0]             addr,
  output logic [REGION_MAX_W-1:0] region,
  output logic                    mapped
);

  localparam int c_REGION_W = (N_REGION > 1) ? $clog2(N_REGION) : 1;

  logic w_hit;
  logic w_unused;

  assign w_unused = ^{addr[23], addr[19:0]};

  always_comb begin
    w_hit  = (addr[31:24] == BRG_BASE[31:24]);
    region = region_of(addr, c_REGION_W);
    mapped = w_hit && ({29'd0, region} < 32'(N_REGION));
  end

endmodule

`default_nettype wire

// File: rtl/fpro_bridge_multi.sv
// ============================================================================
// Module   : fpro_bridge_multi
// Brief    : MCS IO-bus to FPro bridge over N_REGION chip-select regions with
//            read latency, wait stretching and unmapped-access termination.
//            Optional macro BRG_TIMEOUT_EN adds a wait timeout and bus_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpro_bridge_multi
  import fpro_brg_pkg::*;
#(
  parameter logic [31:0] BRG_BASE    = 32'hc000_0000,
  parameter int          N_REGION    = 2,
  parameter int          RD_LAT      = 0,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    io_addr_strobe,
  input  logic                    io_read_strobe,
  input  logic                    io_write_strobe,
  input  logic [3:0]              io_byte_enable,
  input  logic [31:0]             io_address,
  input  logic [31:0]             io_write_data,
  output logic [31:0]             io_read_data,
  output logic                    io_ready,
  output logic [N_REGION-1:0]     fp_cs,
  output logic                    fp_wr,
  output logic                    fp_rd,
  output logic [FP_ADDR_W-1:0]    fp_addr,
  output logic [3:0]              fp_be,
  output logic [31:0]             fp_wr_data,
  input  logic [32*N_REGION-1:0]  fp_rd_data,
  input  logic                    fp_wait,
  output logic                    bus_err
);

  // WAIT holds RD_LAT cycles, so the counter is loaded one short of RD_LAT.
  localparam logic [2:0] c_LAT_LOAD = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  brg_state_t              r_state;
  logic [REGION_MAX_W-1:0] r_region;
  logic                    r_is_write;
  logic                    r_mapped;
  logic [2:0]              r_lat_cnt;

  logic [REGION_MAX_W-1:0] w_region;
  logic                    w_mapped;
  logic [N_REGION-1:0]     w_cs_sel;
  logic [31:0]             w_rd_word;
  logic                    w_unused;

  assign w_unused = io_read_strobe;

  fpro_brg_decode #(
    .BRG_BASE (BRG_BASE),
    .N_REGION (N_REGION)
  ) u_decode (
    .addr   (io_address),
    .region (w_region),
    .mapped (w_mapped)
  );

  always_comb begin
    w_cs_sel  = '0;
    w_rd_word = '0;
    for (int r = 0; r < N_REGION; r++) begin
      w_cs_sel[r] = (w_region == REGION_MAX_W'(r));
      if (r_region == REGION_MAX_W'(r)) begin
        w_rd_word = fp_rd_data[32*r +: 32];
      end
    end
  end

`ifdef BRG_TIMEOUT_EN
  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] r_wait_cnt;
`else
  logic [15:0] w_unused_to;
  assign w_unused_to = 16'(TIMEOUT_CYC);
  assign bus_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_region     <= '0;
      r_is_write   <= 1'b0;
      r_mapped     <= 1'b0;
      r_lat_cnt    <= '0;
      fp_cs        <= '0;
      fp_wr        <= 1'b0;
      fp_rd        <= 1'b0;
      fp_addr      <= '0;
      fp_be        <= '0;
      fp_wr_data   <= '0;
      io_ready     <= 1'b0;
      io_read_data <= '0;
`ifdef BRG_TIMEOUT_EN
      r_wait_cnt   <= '0;
      bus_err      <= 1'b0;
`endif
    end else begin
      io_ready <= 1'b0;
      fp_cs    <= '0;
      fp_wr    <= 1'b0;
      fp_rd    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_addr_strobe) begin
            fp_addr    <= io_address[22:2];
            fp_be      <= io_byte_enable;
            fp_wr_data <= io_write_data;
            r_region   <= w_region;
            r_is_write <= io_write_strobe;
            r_mapped   <= w_mapped;
            fp_cs      <= w_mapped ? w_cs_sel : '0;
            fp_wr      <= w_mapped && io_write_strobe;
            fp_rd      <= w_mapped && !io_write_strobe;
            // Unmapped accesses still spend one ACCESS cycle (no select) so
            // every unstretched access completes two cycles after the strobe.
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
`ifdef BRG_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
          if (!r_mapped) begin
            if (!r_is_write) io_read_data <= '0;
            io_ready <= 1'b1;
            r_state  <= DONE;
          end else if (r_is_write) begin
            io_ready <= 1'b1;
            r_state  <= DONE;
          end else if (RD_LAT == 0 && !fp_wait) begin
            io_read_data <= w_rd_word;
            io_ready     <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_lat_cnt <= c_LAT_LOAD;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (r_lat_cnt != 3'd0) r_lat_cnt <= r_lat_cnt - 3'd1;
          if (r_lat_cnt == 3'd0 && !fp_wait) begin
            io_read_data <= w_rd_word;
            io_ready     <= 1'b1;
            r_state      <= DONE;
          end
`ifdef BRG_TIMEOUT_EN
          else if (fp_wait && r_wait_cnt == c_TO_LAST) begin
            io_read_data <= BRG_ERR_DATA;
            bus_err      <= 1'b1;
            io_ready     <= 1'b1;
            r_state      <= DONE;
          end else if (fp_wait) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
`endif
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpro_bridge_multi.sv
// ============================================================================
// Module   : tb_fpro_bridge_multi
// Brief    : Self-checking bench: three bridge configurations driven with
//            directed and random accesses against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpro_bridge_multi;

  localparam int TO = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  stb;
  logic        rd_s, wr_s;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        fp_wait;
  logic [255:0] rd_bus;

  logic [1:0]  cs0;
  logic [3:0]  cs1;
  logic [2:0]  cs2;
  logic [7:0]  o_cs    [3];
  logic [31:0] o_rdata [3];
  logic        o_rdy   [3];
  logic        o_wr    [3];
  logic        o_rd    [3];
  logic [20:0] o_addr  [3];
  logic [3:0]  o_be    [3];
  logic [31:0] o_wdata [3];
  logic        o_err   [3];

  assign o_cs[0] = {6'd0, cs0};
  assign o_cs[1] = {4'd0, cs1};
  assign o_cs[2] = {5'd0, cs2};

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] model_rd  [3];
  bit          model_err [3];

  always #5 clk = ~clk;

  fpro_bridge_multi #(.N_REGION(2), .RD_LAT(0), .TIMEOUT_CYC(TO)) dut_a (
    .clk(clk), .reset(reset), .io_addr_strobe(stb[0]), .io_read_strobe(rd_s),
    .io_write_strobe(wr_s), .io_byte_enable(be), .io_address(addr),
    .io_write_data(wdata), .io_read_data(o_rdata[0]), .io_ready(o_rdy[0]),
    .fp_cs(cs0), .fp_wr(o_wr[0]), .fp_rd(o_rd[0]), .fp_addr(o_addr[0]),
    .fp_be(o_be[0]), .fp_wr_data(o_wdata[0]), .fp_rd_data(rd_bus[63:0]),
    .fp_wait(fp_wait), .bus_err(o_err[0]));

  fpro_bridge_multi #(.N_REGION(4), .RD_LAT(2), .TIMEOUT_CYC(TO)) dut_b (
    .clk(clk), .reset(reset), .io_addr_strobe(stb[1]), .io_read_strobe(rd_s),
    .io_write_strobe(wr_s), .io_byte_enable(be), .io_address(addr),
    .io_write_data(wdata), .io_read_data(o_rdata[1]), .io_ready(o_rdy[1]),
    .fp_cs(cs1), .fp_wr(o_wr[1]), .fp_rd(o_rd[1]), .fp_addr(o_addr[1]),
    .fp_be(o_be[1]), .fp_wr_data(o_wdata[1]), .fp_rd_data(rd_bus[127:0]),
    .fp_wait(fp_wait), .bus_err(o_err[1]));

  fpro_bridge_multi #(.N_REGION(3), .RD_LAT(0), .TIMEOUT_CYC(TO)) dut_c (
    .clk(clk), .reset(reset), .io_addr_strobe(stb[2]), .io_read_strobe(rd_s),
    .io_write_strobe(wr_s), .io_byte_enable(be), .io_address(addr),
    .io_write_data(wdata), .io_read_data(o_rdata[2]), .io_ready(o_rdy[2]),
    .fp_cs(cs2), .fp_wr(o_wr[2]), .fp_rd(o_rd[2]), .fp_addr(o_addr[2]),
    .fp_be(o_be[2]), .fp_wr_data(o_wdata[2]), .fp_rd_data(rd_bus[95:0]),
    .fp_wait(fp_wait), .bus_err(o_err[2]));

  function automatic int nreg(input int inst);
    return (inst == 0) ? 2 : (inst == 1) ? 4 : 3;
  endfunction

  function automatic int rlat(input int inst);
    return (inst == 1) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic randomize_rd_bus();
    for (int i = 0; i < 8; i++) rd_bus[32*i +: 32] = $urandom;
  endtask

  // One complete access on instance inst; fp_wait is high in cycles 1..k.
  task automatic run_access(input int inst, input bit wr, input bit both,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b, input int k);
    int n, lat, w, reg_i, s, ready;
    bit mapped, tmo;
    logic [31:0] snap, exp_rd;
    logic [63:0] exp_cs;
    n      = nreg(inst);
    lat    = rlat(inst);
    w      = (n <= 2) ? 1 : (n <= 4) ? 2 : 3;
    reg_i  = int'((a >> (23 - w)) % (32'd1 << w));
    mapped = (a[31:24] == 8'hC0) && (reg_i < n);
    s      = -1;
    tmo    = 1'b0;
    snap   = '0;
    if (!mapped || wr) ready = 2;
    else begin
      s     = (1 + lat > k + 1) ? 1 + lat : k + 1;
      ready = s + 1;
    end
`ifdef BRG_TIMEOUT_EN
    if (mapped && !wr && k >= 1 + TO) begin
      tmo   = 1'b1;
      s     = -1;
      ready = 2 + TO;
    end
`endif
    for (int c = 0; c <= ready; c++) begin
      stb = '0;
      if (c == 0) begin
        stb[inst] = 1'b1;
        addr = a; wdata = d; be = b; wr_s = wr; rd_s = !wr || both;
      end else if (c == 1 || c == ready) begin
        stb[inst] = 1'b1;
        addr = $urandom; wdata = $urandom; be = 4'($urandom);
      end
      fp_wait = (c >= 1 && c <= k);
      randomize_rd_bus();
      if (c == s) snap = rd_bus[32*reg_i +: 32];
      @(negedge clk);
      exp_cs = (c == 1 && mapped) ? (64'd1 << reg_i) : 64'd0;
      chk("fp_cs", 64'(o_cs[inst]), exp_cs);
      chk("fp_rd", 64'(o_rd[inst]), 64'(c == 1 && mapped && !wr));
      chk("fp_wr", 64'(o_wr[inst]), 64'(c == 1 && mapped && wr));
      chk("io_ready", 64'(o_rdy[inst]), 64'(c == ready));
      if (c == 1 && mapped) begin
        chk("fp_addr", 64'(o_addr[inst]), 64'(a[22:2]));
        chk("fp_be", 64'(o_be[inst]), 64'(b));
        chk("fp_wr_data", 64'(o_wdata[inst]), 64'(d));
      end
      if (c == ready) begin
        exp_rd = model_rd[inst];
        if (tmo) exp_rd = 32'hDEAD_BEEF;
        else if (!wr) exp_rd = mapped ? snap : 32'd0;
        model_rd[inst] = exp_rd;
        if (tmo) model_err[inst] = 1'b1;
        chk("io_read_data", 64'(o_rdata[inst]), 64'(exp_rd));
        chk("bus_err", 64'(o_err[inst]), 64'(model_err[inst]));
      end
      @(posedge clk);
      #1;
    end
    stb     = '0;
    fp_wait = 1'b0;
  endtask

  task automatic check_all_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_cs"}, 64'(o_cs[i]), 64'd0);
      chk({tag, "_rdwr"}, 64'({o_rd[i], o_wr[i]}), 64'd0);
      chk({tag, "_ready"}, 64'(o_rdy[i]), 64'd0);
      chk({tag, "_rdata"}, 64'(o_rdata[i]), 64'd0);
      chk({tag, "_err"}, 64'(o_err[i]), 64'd0);
      chk({tag, "_addr_be"}, 64'({o_addr[i], o_be[i]}), 64'd0);
      chk({tag, "_wdata"}, 64'(o_wdata[i]), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1; stb = '0; rd_s = 1'b0; wr_s = 1'b0; be = '0;
    addr = '0; wdata = '0; fp_wait = 1'b0; rd_bus = '0;
    for (int i = 0; i < 3; i++) begin model_rd[i] = '0; model_err[i] = 1'b0; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_reset("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed accesses
    run_access(0, 1'b1, 1'b0, 32'hC000_0010, 32'h1234_5678, 4'b0011, 0);
    run_access(1, 1'b0, 1'b0, 32'hC060_0000, 32'h0, 4'hF, 0);
    run_access(0, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 0);
    run_access(2, 1'b0, 1'b0, 32'hC060_0000, 32'h0, 4'hF, 0);
    run_access(0, 1'b0, 1'b0, 32'hC000_0100, 32'h0, 4'hF, 5);
    run_access(0, 1'b1, 1'b1, 32'hC040_0008, 32'hCAFE_F00D, 4'b1100, 0);

    // Randomized accesses across the three configurations
    for (int t = 0; t < 150; t++) begin
      int inst;
      bit wr;
      logic [31:0] a;
      inst = int'($urandom % 3);
      wr   = 1'($urandom);
      a    = ($urandom % 4 != 0) ? {8'hC0, 24'($urandom)} : $urandom;
      run_access(inst, wr, wr && 1'($urandom), a, $urandom, 4'($urandom),
                 int'($urandom % 4));
    end

    // Asynchronous reset in the middle of a latency read (WAIT state)
    run_access(1, 1'b0, 1'b0, 32'hC020_0000, 32'h0, 4'hF, 0);
    stb = 3'b010; addr = 32'hC040_0004; rd_s = 1'b1; wr_s = 1'b0;
    randomize_rd_bus();
    @(posedge clk); #1;
    stb = '0;
    @(posedge clk); #1;
    #2;
    reset = 1'b1;
    #1;
    check_all_reset("async_reset");
    for (int i = 0; i < 3; i++) begin model_rd[i] = '0; model_err[i] = 1'b0; end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_ready_after_reset", 64'(o_rdy[1]), 64'd0);
    end
    @(posedge clk); #1;
    run_access(1, 1'b0, 1'b0, 32'hC040_0004, 32'h0, 4'hF, 1);

`ifdef BRG_TIMEOUT_EN
    run_access(0, 1'b0, 1'b0, 32'hC000_0020, 32'h0, 4'hF, 20);
    run_access(0, 1'b1, 1'b0, 32'hC000_0024, 32'h5555_AAAA, 4'hF, 0);
    run_access(0, 1'b0, 1'b0, 32'hC000_0028, 32'h0, 4'hF, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
